// File: rtl/common_pkg.sv
// Shared fetch-side types and constants: PC and thread-id types, boot and handler vectors.
package common;

  localparam int unsigned n_threads = 8;

  typedef logic [31:0]                  vptr_t;
  typedef logic [$clog2(n_threads)-1:0] threadid_t;

  localparam vptr_t exchandler_pc = 32'h0000_2000;

  // Each thread boots 0x100 below the previous one.
  localparam vptr_t boot_pc [n_threads] = '{
    32'h0000_1700, 32'h0000_1600, 32'h0000_1500, 32'h0000_1400,
    32'h0000_1300, 32'h0000_1200, 32'h0000_1100, 32'h0000_1000
  };

  typedef struct packed {
    vptr_t     pc;
    threadid_t tid;
  } fetch_req_t;

endpackage

// File: rtl/thread_state_pkg.sv
// Run/blocked state of a hardware thread at the fetch front end.
package thread_state;

  typedef enum logic {
    run,
    blocked
  } thread_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: first set req bit scanning circularly from ptr.
module rr_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            gnt_valid,
  output logic [IdxW-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_valid && req[(32'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/thread_fetch_sched.sv
// Per-thread PC/EPC holder and round-robin fetch scheduler.
// Optional per-thread accepted-request counters when FETCH_PERF_EN is defined.
module thread_fetch_sched
  import common::*;
  import thread_state::*;
#(
  parameter int unsigned N_THREADS = common::n_threads,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic      clk,
  input  logic      rst,
  output logic      out_valid,
  input  logic      out_ready,
  output vptr_t     out_pc,
  output threadid_t out_tid,
  input  logic      stall_valid,
  input  threadid_t stall_tid,
  input  logic      wake_valid,
  input  threadid_t wake_tid,
  input  logic      redir_valid,
  input  threadid_t redir_tid,
  input  vptr_t     redir_pc,
  input  logic      exc_valid,
  input  threadid_t exc_tid,
  input  vptr_t     exc_pc,
  input  threadid_t epc_rd_tid,
`ifdef FETCH_PERF_EN
  input  threadid_t perf_rd_tid,
  output logic [31:0] perf_rd_data,
`endif
  output vptr_t     epc_rd_data
);

  vptr_t         pc_q    [N_THREADS];
  vptr_t         pc_d    [N_THREADS];
  vptr_t         epc_q   [N_THREADS];
  vptr_t         epc_d   [N_THREADS];
  thread_state_t state_q [N_THREADS];
  thread_state_t state_d [N_THREADS];

  threadid_t  rr_ptr_q, rr_ptr_d;
  logic       out_valid_q, out_valid_d;
  fetch_req_t out_q, out_d;

  logic [N_THREADS-1:0] stall_hit, wake_hit, redir_hit, exc_hit, issue_hit, elig;
  logic      load, issue, squash, gnt_valid;
  threadid_t gnt_idx;

  rr_arbiter #(
    .N    (N_THREADS),
    .IdxW ($bits(threadid_t))
  ) u_arb (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Out-of-range tids decode to no thread at all.
  always_comb begin
    stall_hit = '0;
    wake_hit  = '0;
    redir_hit = '0;
    exc_hit   = '0;
    if (stall_valid && 32'(stall_tid) < N_THREADS) stall_hit[stall_tid] = 1'b1;
    if (wake_valid  && 32'(wake_tid)  < N_THREADS) wake_hit[wake_tid]   = 1'b1;
    if (redir_valid && 32'(redir_tid) < N_THREADS) redir_hit[redir_tid] = 1'b1;
    if (exc_valid   && 32'(exc_tid)   < N_THREADS) exc_hit[exc_tid]     = 1'b1;
    for (int unsigned i = 0; i < N_THREADS; i++) begin
      elig[i] = (state_q[i] == run) && !stall_hit[i] && !redir_hit[i] && !exc_hit[i];
    end
  end

  always_comb begin
    load      = !out_valid_q || out_ready;
    issue     = load && gnt_valid;
    squash    = out_valid_q && !out_ready &&
                ((exc_valid && exc_tid == out_q.tid) || (redir_valid && redir_tid == out_q.tid));
    issue_hit = '0;
    if (issue) issue_hit[gnt_idx] = 1'b1;

    pc_d    = pc_q;
    epc_d   = epc_q;
    state_d = state_q;
    for (int unsigned i = 0; i < N_THREADS; i++) begin
      if (issue_hit[i]) pc_d[i] = pc_q[i] + vptr_t'(PC_STEP);
      if (wake_hit[i])  state_d[i] = run;
      if (stall_hit[i]) state_d[i] = blocked;
      if (redir_hit[i]) pc_d[i] = redir_pc;
      if (exc_hit[i]) begin
        epc_d[i]   = exc_pc;
        pc_d[i]    = exchandler_pc;
        state_d[i] = run;
      end
    end

    out_valid_d = out_valid_q;
    out_d       = out_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_d.pc  = pc_q[gnt_idx];
        out_d.tid = gnt_idx;
        rr_ptr_d  = threadid_t'((32'(gnt_idx) + 1) % N_THREADS);
      end
    end else if (squash) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        pc_q[i]    <= boot_pc[i];
        epc_q[i]   <= '0;
        state_q[i] <= run;
      end
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_tid     = out_q.tid;
  assign epc_rd_data = epc_q[epc_rd_tid];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q [N_THREADS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_THREADS; i++) perf_q[i] <= '0;
    end else if (out_valid_q && out_ready) begin
      perf_q[out_q.tid] <= perf_q[out_q.tid] + 32'd1;
    end
  end

  assign perf_rd_data = perf_q[perf_rd_tid];
`endif

endmodule
